// File: rtl/opcode_trace_buffer.sv
// ============================================================================
// Module   : opcode_trace_buffer
// Purpose  : Circular capture of retired 65C02 opcode fetches (PC + opcode),
//            frozen after a trigger and replayed oldest-first on a
//            valid/ready port that feeds the mnemonic decoder.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module opcode_trace_buffer #(
  parameter int DEPTH_LOG2 = 6,
  parameter int POST_TRIG  = 16
) (
  input  logic                  clk,
  input  logic                  RST,
  input  logic                  fetch_valid,
  input  logic [15:0]           fetch_pc,
  input  logic [7:0]            fetch_op,
  input  logic                  arm,
  input  logic                  trig_en,
  input  logic [15:0]           trig_pc,
  input  logic                  force_trig,
  output logic                  rd_valid,
  input  logic                  rd_ready,
  output logic [15:0]           rd_pc,
  output logic [7:0]            rd_op,
  output logic                  rd_last,
  output logic [1:0]            state,
  output logic [DEPTH_LOG2:0]   fill
);

  localparam int                  c_depth_int = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] c_depth     = (DEPTH_LOG2+1)'(c_depth_int);
  localparam logic [DEPTH_LOG2:0] c_one       = (DEPTH_LOG2+1)'(1);
  localparam logic [DEPTH_LOG2-1:0] c_ptr_one   = DEPTH_LOG2'(1);
  localparam logic [DEPTH_LOG2-1:0] c_post_trig = DEPTH_LOG2'(POST_TRIG);

  generate
    if (POST_TRIG < 0 || POST_TRIG > c_depth_int - 1) begin : g_bad_post_trig
      $error("opcode_trace_buffer: POST_TRIG must be within 0..2**DEPTH_LOG2-1");
    end
  endgenerate

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ARMED = 2'd1,
    S_POST  = 2'd2,
    S_DUMP  = 2'd3
  } state_t;

  state_t                  r_state;
  state_t                  w_state_nxt;
  logic                    w_post_load;
  logic                    w_dump_enter;

  logic [23:0]             r_mem [c_depth_int];
  logic [23:0]             r_rdata;

  logic [DEPTH_LOG2-1:0]   r_wptr;
  logic [DEPTH_LOG2:0]     r_fill;
  logic [DEPTH_LOG2-1:0]   r_post_cnt;
  logic [DEPTH_LOG2-1:0]   r_rptr;
  logic [DEPTH_LOG2:0]     r_remain;
  logic                    r_rd_req;
  logic                    r_rdata_vld;
  logic                    r_rd_valid;
  logic                    r_rd_last;
  logic [15:0]             r_rd_pc;
  logic [7:0]              r_rd_op;

  logic                    w_trig;
  logic                    w_capture;
  logic [DEPTH_LOG2-1:0]   w_wr_addr;
  logic [DEPTH_LOG2-1:0]   w_wptr_nxt;
  logic [DEPTH_LOG2:0]     w_fill_base;
  logic [DEPTH_LOG2:0]     w_fill_nxt;
  logic                    w_xfer;
  logic                    w_rd_en;

  assign w_trig = (trig_en && fetch_valid && (fetch_pc == trig_pc)) || force_trig;
  assign w_xfer = r_rd_valid && rd_ready;

  // arm restarts the history; a fetch on the arm cycle lands in slot 0
  assign w_capture   = arm ? fetch_valid
                           : (fetch_valid && (r_state == S_ARMED || r_state == S_POST));
  assign w_wr_addr   = arm ? '0 : r_wptr;
  assign w_wptr_nxt  = w_capture ? (w_wr_addr + c_ptr_one) : w_wr_addr;
  assign w_fill_base = arm ? '0 : r_fill;
  assign w_fill_nxt  = (w_capture && (w_fill_base != c_depth)) ? (w_fill_base + c_one)
                                                               : w_fill_base;

  // Memory reads happen on the first DUMP cycle and on every non-final transfer
  assign w_rd_en = !arm && (r_state == S_DUMP) &&
                   ((r_rd_req && (r_remain != '0)) || (w_xfer && !r_rd_last));

  always_comb begin
    w_state_nxt  = r_state;
    w_post_load  = 1'b0;
    w_dump_enter = 1'b0;
    if (arm) begin
      w_state_nxt = S_ARMED;
    end else begin
      case (r_state)
        S_ARMED: begin
          if (w_trig) begin
            if (POST_TRIG == 0) begin
              w_state_nxt  = S_DUMP;
              w_dump_enter = 1'b1;
            end else begin
              w_state_nxt = S_POST;
              w_post_load = 1'b1;
            end
          end
        end
        S_POST: begin
          if (fetch_valid && (r_post_cnt == c_ptr_one)) begin
            w_state_nxt  = S_DUMP;
            w_dump_enter = 1'b1;
          end
        end
        S_DUMP: begin
          if ((r_rd_req && (r_remain == '0)) || (w_xfer && r_rd_last)) begin
            w_state_nxt = S_IDLE;
          end
        end
        default: begin
          w_state_nxt = r_state;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge RST) begin
    if (RST) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Storage has no reset so it can map onto block RAM
  always_ff @(posedge clk) begin
    if (w_capture) begin
      r_mem[w_wr_addr] <= {fetch_pc, fetch_op};
    end
    if (w_rd_en) begin
      r_rdata <= r_mem[r_rptr];
    end
  end

  always_ff @(posedge clk or posedge RST) begin
    if (RST) begin
      r_wptr      <= '0;
      r_fill      <= '0;
      r_post_cnt  <= '0;
      r_rptr      <= '0;
      r_remain    <= '0;
      r_rd_req    <= 1'b0;
      r_rdata_vld <= 1'b0;
      r_rd_valid  <= 1'b0;
      r_rd_last   <= 1'b0;
      r_rd_pc     <= '0;
      r_rd_op     <= '0;
    end else begin
      r_wptr <= w_wptr_nxt;
      r_fill <= w_fill_nxt;

      if (arm) begin
        r_post_cnt <= '0;
      end else if (w_post_load) begin
        r_post_cnt <= c_post_trig;
      end else if (r_state == S_POST && fetch_valid) begin
        r_post_cnt <= r_post_cnt - c_ptr_one;
      end

      if (arm) begin
        r_rd_req    <= 1'b0;
        r_rdata_vld <= 1'b0;
        r_rd_valid  <= 1'b0;
        r_rd_last   <= 1'b0;
      end else begin
        if (w_dump_enter) begin
          // Oldest entry sits fill slots behind the write pointer
          r_rptr   <= w_wptr_nxt - w_fill_nxt[DEPTH_LOG2-1:0];
          r_remain <= w_fill_nxt;
          r_rd_req <= 1'b1;
        end
        if (r_rd_req) begin
          r_rd_req <= 1'b0;
        end
        if (w_rd_en) begin
          r_rptr      <= r_rptr + c_ptr_one;
          r_rdata_vld <= 1'b1;
        end else if (r_rdata_vld) begin
          r_rd_valid  <= 1'b1;
          r_rd_pc     <= r_rdata[23:8];
          r_rd_op     <= r_rdata[7:0];
          r_rd_last   <= (r_remain == c_one);
          r_remain    <= r_remain - c_one;
          r_rdata_vld <= 1'b0;
        end
        if (w_xfer) begin
          r_rd_valid <= 1'b0;
          r_rd_last  <= 1'b0;
        end
      end
    end
  end

  assign rd_valid = r_rd_valid;
  assign rd_pc    = r_rd_pc;
  assign rd_op    = r_rd_op;
  assign rd_last  = r_rd_last;
  assign state    = r_state;
  assign fill     = r_fill;

endmodule

`default_nettype wire

// File: tb/tb_opcode_trace_buffer.sv
// ============================================================================
// Module   : tb_opcode_trace_buffer
// Purpose  : Directed bench for opcode_trace_buffer; two instances
//            (POST_TRIG=2 and POST_TRIG=0) share stimulus and a list model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_opcode_trace_buffer;

  logic        clk = 1'b0;
  logic        RST = 1'b1;
  logic        fetch_valid = 1'b0;
  logic [15:0] fetch_pc = '0;
  logic [7:0]  fetch_op = '0;
  logic        arm = 1'b0;
  logic        trig_en = 1'b0;
  logic [15:0] trig_pc = '0;
  logic        force_trig = 1'b0;
  logic        rd_ready = 1'b0;

  logic        d_valid [2];
  logic        d_last  [2];
  logic [15:0] d_pc    [2];
  logic [7:0]  d_op    [2];
  logic [1:0]  d_state [2];
  logic [3:0]  d_fill  [2];

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  opcode_trace_buffer #(.DEPTH_LOG2(3), .POST_TRIG(2)) dut (
    .clk(clk), .RST(RST), .fetch_valid(fetch_valid), .fetch_pc(fetch_pc),
    .fetch_op(fetch_op), .arm(arm), .trig_en(trig_en), .trig_pc(trig_pc),
    .force_trig(force_trig), .rd_valid(d_valid[0]), .rd_ready(rd_ready),
    .rd_pc(d_pc[0]), .rd_op(d_op[0]), .rd_last(d_last[0]),
    .state(d_state[0]), .fill(d_fill[0])
  );

  opcode_trace_buffer #(.DEPTH_LOG2(3), .POST_TRIG(0)) dut0 (
    .clk(clk), .RST(RST), .fetch_valid(fetch_valid), .fetch_pc(fetch_pc),
    .fetch_op(fetch_op), .arm(arm), .trig_en(trig_en), .trig_pc(trig_pc),
    .force_trig(force_trig), .rd_valid(d_valid[1]), .rd_ready(rd_ready),
    .rd_pc(d_pc[1]), .rd_op(d_op[1]), .rd_last(d_last[1]),
    .state(d_state[1]), .fill(d_fill[1])
  );

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model: history as an ordered list ----------
  int          m_state [2];
  int          m_n     [2];
  int          m_post  [2];
  bit          m_vld   [2];
  int          m_wait  [2];
  int          m_rdi   [2];
  logic [23:0] m_hist  [2][8];

  function automatic int pt(int k);
    return (k == 0) ? 2 : 0;
  endfunction

  task automatic m_push(int k, logic [23:0] e);
    if (m_n[k] == 8) begin
      for (int i = 0; i < 7; i++) m_hist[k][i] = m_hist[k][i+1];
      m_hist[k][7] = e;
    end else begin
      m_hist[k][m_n[k]] = e;
      m_n[k]++;
    end
  endtask

  task automatic m_dump(int k);
    m_state[k] = 3;
    m_rdi[k]   = 0;
    m_vld[k]   = 1'b0;
    m_wait[k]  = (m_n[k] == 0) ? 1 : 2;
  endtask

  task automatic m_reset();
    for (int k = 0; k < 2; k++) begin
      m_state[k] = 0; m_n[k] = 0; m_post[k] = 0;
      m_vld[k] = 1'b0; m_wait[k] = 0; m_rdi[k] = 0;
    end
  endtask

  task automatic m_step(int k);
    bit trig;
    trig = (trig_en && fetch_valid && fetch_pc == trig_pc) || force_trig;
    if (arm) begin
      m_n[k] = 0; m_state[k] = 1; m_vld[k] = 1'b0; m_wait[k] = 0;
      if (fetch_valid) m_push(k, {fetch_pc, fetch_op});
    end else begin
      case (m_state[k])
        1: begin
          if (fetch_valid) m_push(k, {fetch_pc, fetch_op});
          if (trig) begin
            if (pt(k) == 0) m_dump(k);
            else begin m_state[k] = 2; m_post[k] = pt(k); end
          end
        end
        2: if (fetch_valid) begin
          m_push(k, {fetch_pc, fetch_op});
          m_post[k]--;
          if (m_post[k] == 0) m_dump(k);
        end
        3: begin
          if (m_vld[k] && rd_ready) begin
            m_vld[k] = 1'b0;
            if (m_rdi[k] == m_n[k] - 1) m_state[k] = 0;
            else begin m_rdi[k]++; m_wait[k] = 1; end
          end else if (!m_vld[k]) begin
            m_wait[k]--;
            if (m_wait[k] == 0) begin
              if (m_n[k] == 0) m_state[k] = 0;
              else m_vld[k] = 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  endtask

  initial begin
    m_reset();
    forever begin
      @(posedge clk or posedge RST);
      if (RST) m_reset();
      else for (int k = 0; k < 2; k++) m_step(k);
    end
  end

  // ---------------- per-cycle comparison against the model ----------------
  initial begin
    forever begin
      @(negedge clk);
      if (!RST) begin
        for (int k = 0; k < 2; k++) begin
          chk($sformatf("state[%0d]", k), d_state[k], m_state[k]);
          chk($sformatf("fill[%0d]", k), d_fill[k], m_n[k]);
          chk($sformatf("rd_valid[%0d]", k), d_valid[k], m_vld[k]);
          chk($sformatf("rd_last[%0d]", k), d_last[k],
              (m_vld[k] && m_rdi[k] == m_n[k] - 1) ? 1 : 0);
          if (m_vld[k]) begin
            chk($sformatf("rd_pc[%0d]", k), d_pc[k], m_hist[k][m_rdi[k]][23:8]);
            chk($sformatf("rd_op[%0d]", k), d_op[k], m_hist[k][m_rdi[k]][7:0]);
          end
        end
      end
    end
  end

  // ---------------- stimulus ----------------------------------------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_fetch(logic [15:0] pc, logic [7:0] op);
    fetch_valid = 1'b1; fetch_pc = pc; fetch_op = op;
    tick();
    fetch_valid = 1'b0;
  endtask

  task automatic do_arm();
    arm = 1'b1;
    tick();
    arm = 1'b0;
  endtask

  task automatic do_force();
    force_trig = 1'b1;
    tick();
    force_trig = 1'b0;
  endtask

  task automatic wait_beat(int k, output logic [15:0] pc, output logic [7:0] op,
                           output logic last);
    bit got;
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      if (d_valid[k]) got = 1'b1;
    end
    chk("beat_timeout", got, 1);
    pc = d_pc[k]; op = d_op[k]; last = d_last[k];
  endtask

  initial begin : stim
    logic [15:0] pc;
    logic [7:0]  op;
    logic        last;
    logic [7:0]  exp_ops [3];
    exp_ops = '{8'hA9, 8'h8D, 8'h4C};

    repeat (3) tick();
    RST = 1'b0;
    @(negedge clk);
    chk("rst_state", d_state[0], 0);
    chk("rst_fill", d_fill[0], 0);
    chk("rst_valid", d_valid[0], 0);
    chk("rst_last", d_last[0], 0);
    chk("rst_pc", d_pc[0], 0);
    chk("rst_op", d_op[0], 0);

    do_fetch(16'h0ABC, 8'h55);
    @(negedge clk);
    chk("idle_fill", d_fill[0], 0);

    // PC-match trigger, short history
    rd_ready = 1'b1; trig_en = 1'b1; trig_pc = 16'h1002;
    do_arm();
    for (int i = 0; i < 5; i++) do_fetch(16'h1000 + 16'(i), 8'(i));
    @(negedge clk);
    chk("t1_state", d_state[0], 3);
    chk("t1_fill", d_fill[0], 5);
    for (int i = 0; i < 5; i++) begin
      wait_beat(0, pc, op, last);
      chk("t1_pc", pc, 16'h1000 + 16'(i));
      chk("t1_last", last, (i == 4) ? 1 : 0);
    end
    repeat (2) @(negedge clk);
    chk("t1_idle", d_state[0], 0);

    // Wrap-around
    trig_pc = 16'h2011;
    do_arm();
    for (int i = 0; i < 20; i++) do_fetch(16'h2000 + 16'(i), 8'h40 + 8'(i));
    @(negedge clk);
    chk("t2_fill", d_fill[0], 8);
    for (int i = 0; i < 8; i++) begin
      wait_beat(0, pc, op, last);
      chk("t2_pc", pc, 16'h200C + 16'(i));
      chk("t2_last", last, (i == 7) ? 1 : 0);
    end

    // Forced trigger with no fetch, POST_TRIG=0 instance
    trig_en = 1'b0;
    repeat (4) tick();
    do_arm();
    do_fetch(16'h4000, 8'hA9);
    do_fetch(16'h4001, 8'h8D);
    do_fetch(16'h4002, 8'h4C);
    do_force();
    @(negedge clk);
    chk("t3_state0", d_state[1], 3);
    for (int i = 0; i < 3; i++) begin
      wait_beat(1, pc, op, last);
      chk("t3_op", op, exp_ops[i]);
      chk("t3_last", last, (i == 2) ? 1 : 0);
    end
    repeat (3) @(negedge clk);
    chk("t3_done_state", d_state[1], 0);
    chk("t3_done_valid", d_valid[1], 0);
    chk("t3_post_state", d_state[0], 2);

    // Back-pressure
    rd_ready = 1'b0;
    do_arm();
    for (int i = 0; i < 3; i++) do_fetch(16'h5000 + 16'(i), 8'h10 + 8'(i));
    do_force();
    do_fetch(16'h5003, 8'h13);
    do_fetch(16'h5004, 8'h14);
    wait_beat(0, pc, op, last);
    chk("bp_first_pc", pc, 16'h5000);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("bp_hold_valid", d_valid[0], 1);
      chk("bp_hold_pc", d_pc[0], 16'h5000);
      chk("bp_hold_op", d_op[0], 8'h10);
    end
    rd_ready = 1'b1;
    @(posedge clk);
    #1 rd_ready = 1'b0;
    wait_beat(0, pc, op, last);
    chk("bp_next_pc", pc, 16'h5001);
    repeat (3) @(negedge clk);
    chk("bp_stays_pc", d_pc[0], 16'h5001);

    // arm + fetch mid-readout
    arm = 1'b1; fetch_valid = 1'b1; fetch_pc = 16'h3000; fetch_op = 8'h11;
    tick();
    arm = 1'b0; fetch_valid = 1'b0;
    @(negedge clk);
    chk("t5_valid", d_valid[0], 0);
    chk("t5_state", d_state[0], 1);
    chk("t5_fill", d_fill[0], 1);
    do_force();
    rd_ready = 1'b1;
    do_fetch(16'h3001, 8'h12);
    do_fetch(16'h3002, 8'h13);
    wait_beat(0, pc, op, last);
    chk("t5_entry0_pc", pc, 16'h3000);
    chk("t5_entry0_op", op, 8'h11);
    repeat (12) tick();
    chk("t5_idle", d_state[0], 0);

    // Reset during POST
    do_arm();
    do_fetch(16'h6000, 8'h60);
    do_force();
    @(negedge clk);
    chk("t6_post", d_state[0], 2);
    #2 RST = 1'b1;
    repeat (2) @(posedge clk);
    #1 RST = 1'b0;
    @(negedge clk);
    chk("t6_state", d_state[0], 0);
    chk("t6_fill", d_fill[0], 0);
    chk("t6_valid", d_valid[1], 0);
    chk("t6_pc", d_pc[1], 0);
    do_fetch(16'h6001, 8'h61);
    do_fetch(16'h6002, 8'h62);
    @(negedge clk);
    chk("t6_ignored_fill", d_fill[0], 0);

    repeat (2) tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire
